// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-stage arbiter in front of the register file's single
// write port. In-order pipeline results always win. Out-of-order MDU results
// are bypassed when nothing else is pending, otherwise buffered in a small FIFO
// and drained in acceptance order. A saturating starve counter asks upstream
// for a bubble when a buffered MDU result has been blocked for too long.
module wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_valid,
  input  logic [ADDRESS_WIDTH-1:0]      pipe_rd,
  input  logic [DATA_WIDTH-1:0]         pipe_data,
  input  logic                          mdu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      mdu_rd,
  input  logic [DATA_WIDTH-1:0]         mdu_data,
  output logic                          mdu_ready,
  output logic                          RegWrite,
  output logic [ADDRESS_WIDTH-1:0]      rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]         rg_wrt_data,
  output logic                          stall_pipe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // Which producer owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  // Pointers wrap naturally because the depth is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // FIFO storage and bookkeeping.
  logic [ADDRESS_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic [STV_W-1:0]         r_starve;

  // Registered write-port outputs.
  logic                     r_reg_write;
  logic [ADDRESS_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0]    r_data;

  // Combinational decode.
  logic                     w_empty;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  src_e                     w_src;
  logic [ADDRESS_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [STV_W-1:0]         w_starve_nxt;

  // Ready depends on stored occupancy only, never on mdu_valid, so a full
  // FIFO cannot pass a result through in the same cycle.
  assign w_empty  = (r_count == CNT_W'(0));
  assign w_ready  = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_accept = mdu_valid && w_ready;

  // Pop whenever the pipe is idle and something is buffered; an accepted MDU
  // result is buffered unless it is taking the bypass slot this cycle.
  assign w_pop  = !pipe_valid && !w_empty;
  assign w_push = w_accept && (pipe_valid || !w_empty);

  // Select the write-port source in fixed priority: pipe, FIFO head, bypass.
  always_comb begin
    w_src      = SRC_NONE;
    w_sel_rd   = {ADDRESS_WIDTH{1'b0}};
    w_sel_data = {DATA_WIDTH{1'b0}};
    if (pipe_valid) begin
      w_src      = SRC_PIPE;
      w_sel_rd   = pipe_rd;
      w_sel_data = pipe_data;
    end else if (!w_empty) begin
      w_src      = SRC_FIFO;
      w_sel_rd   = r_fifo_rd[r_rd_ptr];
      w_sel_data = r_fifo_data[r_rd_ptr];
    end else if (w_accept) begin
      w_src      = SRC_MDU;
      w_sel_rd   = mdu_rd;
      w_sel_data = mdu_data;
    end else begin
      w_src      = SRC_NONE;
      w_sel_rd   = {ADDRESS_WIDTH{1'b0}};
      w_sel_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next starve count: grows while a buffered result is blocked by the pipe,
  // saturates at the limit, clears on any pop or when nothing is buffered.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = {STV_W{1'b0}};
    end else if (pipe_valid) begin
      if (r_starve == STV_W'(STARVE_LIMIT)) begin
        w_starve_nxt = r_starve;
      end else begin
        w_starve_nxt = r_starve + STV_W'(1);
      end
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // FIFO pointers, occupancy and starve counter; reset discards all entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_starve <= {STV_W{1'b0}};
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // FIFO payload storage, written at the tail on each push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_rd[i]   <= {ADDRESS_WIDTH{1'b0}};
        r_fifo_data[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= mdu_rd;
      r_fifo_data[r_wr_ptr] <= mdu_data;
    end else begin
      r_fifo_rd[r_wr_ptr]   <= r_fifo_rd[r_wr_ptr];
      r_fifo_data[r_wr_ptr] <= r_fifo_data[r_wr_ptr];
    end
  end

  // Register the write port. A selection targeting x0 is consumed but not
  // written; with no selection the address and data simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write <= 1'b0;
      r_dest      <= {ADDRESS_WIDTH{1'b0}};
      r_data      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (w_src)
        SRC_PIPE, SRC_FIFO, SRC_MDU: begin
          if (w_sel_rd != {ADDRESS_WIDTH{1'b0}}) begin
            r_reg_write <= 1'b1;
            r_dest      <= w_sel_rd;
            r_data      <= w_sel_data;
          end else begin
            r_reg_write <= 1'b0;
          end
        end
        default: begin
          r_reg_write <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_ready   = w_ready;
  assign RegWrite    = r_reg_write;
  assign rg_wrt_dest = r_dest;
  assign rg_wrt_data = r_data;
  assign stall_pipe  = (r_starve == STV_W'(STARVE_LIMIT));
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as each cycle's
// stimulus is driven and compared one cycle later when the write port updates.
module tb_wb_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int SL    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pipe_valid;
  logic [AW-1:0]           pipe_rd;
  logic [DW-1:0]           pipe_data;
  logic                    mdu_valid;
  logic [AW-1:0]           mdu_rd;
  logic [DW-1:0]           mdu_data;
  logic                    mdu_ready;
  logic                    RegWrite;
  logic [AW-1:0]           rg_wrt_dest;
  logic [DW-1:0]           rg_wrt_data;
  logic                    stall_pipe;
  logic [$clog2(DEPTH):0]  fifo_count;

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  wb_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .RegWrite(RegWrite),
    .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .stall_pipe(stall_pipe), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue this cycle's expected write, clock once, then check the write port.
  task automatic cyc(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                     input string tag);
    exp_t e;
    exp_t got;
    e.we = we; e.rd = rd; e.data = d;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      got = q.pop_front();
      chk({tag, "_we"}, DW'(RegWrite), DW'(got.we));
      if (got.we) begin
        chk({tag, "_dest"}, DW'(rg_wrt_dest), DW'(got.rd));
        chk({tag, "_data"}, rg_wrt_data, got.data);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    DW'(RegWrite), 32'd0);
    chk("rst_dest",  DW'(rg_wrt_dest), 32'd0);
    chk("rst_data",  rg_wrt_data, 32'd0);
    chk("rst_stall", DW'(stall_pipe), 32'd0);
    chk("rst_count", DW'(fifo_count), 32'd0);
    chk("rst_ready", DW'(mdu_ready), 32'd1);
    rst = 1'b0;

    // Single pipeline write, then idle.
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    cyc(1'b1, 5'd5, 32'hDEADBEEF, "pipe_one");
    pipe_valid = 1'b0;
    cyc(1'b0, 5'd0, 32'd0, "pipe_idle");

    // Bypass with an empty FIFO.
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12;
    chk("bypass_ready", DW'(mdu_ready), 32'd1);
    cyc(1'b1, 5'd7, 32'h12, "bypass");
    mdu_valid = 1'b0;
    chk("bypass_count", DW'(fifo_count), 32'd0);

    // Pipe burst blocks two buffered MDU results, then they drain in order.
    for (int i = 0; i < 8; i++) begin
      pipe_valid = 1'b1; pipe_rd = AW'(10 + i); pipe_data = 32'h100 + DW'(i);
      if (i == 0) begin
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hA;
      end else if (i == 1) begin
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'hB;
        chk("burst_ready1", DW'(mdu_ready), 32'd1);
      end else begin
        mdu_valid = 1'b0;
      end
      cyc(1'b1, AW'(10 + i), 32'h100 + DW'(i), "burst");
      if (i == 1) begin
        chk("burst_count2", DW'(fifo_count), 32'd2);
        chk("burst_full_ready", DW'(mdu_ready), 32'd0);
      end
      if (i == 3) chk("burst_stall_lo", DW'(stall_pipe), 32'd0);
      if (i == 4 || i == 7) chk("burst_stall_hi", DW'(stall_pipe), 32'd1);
    end
    pipe_valid = 1'b0;
    cyc(1'b1, 5'd3, 32'hA, "drain_first");
    chk("drain_stall", DW'(stall_pipe), 32'd0);
    chk("drain_count1", DW'(fifo_count), 32'd1);
    cyc(1'b1, 5'd4, 32'hB, "drain_second");
    chk("drain_count0", DW'(fifo_count), 32'd0);

    // Writes to x0 are suppressed but still consumed.
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
    cyc(1'b0, 5'd0, 32'd0, "pipe_x0");
    pipe_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h55;
    cyc(1'b0, 5'd0, 32'd0, "mdu_x0");
    mdu_valid = 1'b0;
    chk("mdu_x0_count", DW'(fifo_count), 32'd0);
    cyc(1'b0, 5'd0, 32'd0, "mdu_x0_after");

    // Simultaneous push and pop with one entry buffered.
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h99;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC;
    cyc(1'b1, 5'd9, 32'h99, "pp_fill");
    chk("pp_count_a", DW'(fifo_count), 32'd1);
    pipe_valid = 1'b0;
    mdu_rd = 5'd13; mdu_data = 32'hD;
    cyc(1'b1, 5'd12, 32'hC, "pp_swap");
    chk("pp_count_b", DW'(fifo_count), 32'd1);
    mdu_valid = 1'b0;
    cyc(1'b1, 5'd13, 32'hD, "pp_drain");
    chk("pp_count_c", DW'(fifo_count), 32'd0);

    // Asynchronous reset with a full FIFO and a live write.
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h20;
    cyc(1'b1, 5'd1, 32'h1, "ar_a");
    pipe_rd = 5'd2; pipe_data = 32'h2; mdu_rd = 5'd21; mdu_data = 32'h21;
    cyc(1'b1, 5'd2, 32'h2, "ar_b");
    chk("ar_pre_count", DW'(fifo_count), 32'd2);
    pipe_valid = 1'b0; mdu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ar_we",    DW'(RegWrite), 32'd0);
    chk("ar_count", DW'(fifo_count), 32'd0);
    chk("ar_ready", DW'(mdu_ready), 32'd1);
    #1;
    rst = 1'b0;
    cyc(1'b0, 5'd0, 32'd0, "ar_post1");
    cyc(1'b0, 5'd0, 32'd0, "ar_post2");
    chk("ar_post_count", DW'(fifo_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter directly upstream of the register file.
- Merges two producers into the register file's single write port: in-order pipeline results and out-of-order results from the multi-cycle multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO and drives RegWrite, rg_wrt_dest and rg_wrt_data from registers.
- Requests a one-cycle pipeline bubble when the buffered MDU result has been starved too long.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDRESS_WIDTH, 5, register address width
- FIFO_DEPTH, 2, MDU result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_pipe asserts (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  pipeline writeback request this cycle; never back-pressured
- pipe_rd  in  ADDRESS_WIDTH  pipeline destination register
- pipe_data  in  DATA_WIDTH  pipeline result
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  ADDRESS_WIDTH  MDU destination register
- mdu_data  in  DATA_WIDTH  MDU result
- mdu_ready  out  1  arbiter accepts MDU result; transfer occurs when mdu_valid && mdu_ready
- RegWrite  out  1  register-file write enable (registered)
- rg_wrt_dest  out  ADDRESS_WIDTH  write address (registered)
- rg_wrt_data  out  DATA_WIDTH  write data (registered)
- stall_pipe  out  1  request that upstream issue no pipe_valid this cycle
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered MDU entries

Behaviour:
- Reset (asynchronous, active-high): RegWrite=0, rg_wrt_dest=0, rg_wrt_data=0, stall_pipe=0, FIFO empty (fifo_count=0), starve counter=0. mdu_ready=1 immediately after reset.
- mdu_ready = (fifo_count < FIFO_DEPTH). Combinational from state only, with no dependence on mdu_valid. No same-cycle pass-through when full.
- Per-cycle source selection, in priority order:
  1. pipe_valid=1 → pipe result.
  2. Else FIFO non-empty → FIFO head (pop).
  3. Else mdu_valid && mdu_ready → bypass the MDU result straight to output; it is not enqueued.
  4. Else no write.
- An accepted MDU result that is not bypassed is enqueued the same edge. Simultaneous push and pop is legal; count is unchanged.
- Output latency is 1 cycle: on the next clk edge, RegWrite=1 and rg_wrt_dest/rg_wrt_data take the selected rd/data.
  - If the selected rd==0, RegWrite=0. The entry is still consumed (popped, or the bypass counted as accepted).
  - With no selection, RegWrite=0 and dest/data hold their previous values.
- Ordering:
  - MDU results leave in acceptance order.
  - Pipeline results are never delayed or dropped.
  - If a pipe write and an MDU write target the same rd, their relative order follows this priority. Hazard resolution is the issue stage's job.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and pipe_valid=1.
  - Clears to 0 on any pop or when the FIFO is empty.
- stall_pipe = (starve counter == STARVE_LIMIT), decoded from the register, so there is no combinational path from inputs.
  - Upstream drives pipe_valid=0 in any cycle with stall_pipe=1; the head then pops and the counter clears.
  - If pipe_valid=1 arrives anyway, the pipe still wins, no data is lost, and stall_pipe stays high.
- Wrap-around: FIFO read/write pointers wrap modulo FIFO_DEPTH.
- Full FIFO with mdu_valid=1: mdu_ready=0, and the MDU holds rd/data stable until accepted.
- Reset mid-operation: all buffered MDU results are discarded. Any in-flight write is cancelled (RegWrite=0 asynchronously).

Test Plan:
- Reset release, pipe_valid=1 rd=5 data=0xDEADBEEF for 1 cycle → next cycle RegWrite=1, dest=5, data=0xDEADBEEF; following cycle RegWrite=0.
- FIFO empty, pipe idle, mdu_valid=1 rd=7 data=0x12 → mdu_ready=1; next cycle write rd=7/0x12 (bypass); fifo_count stays 0.
- pipe_valid=1 for 8 consecutive cycles; mdu offers rd=3/0xA then rd=4/0xB:
  - both enqueued, fifo_count=2, mdu_ready=0;
  - stall_pipe=1 after 4 blocked cycles;
  - when the bench drops pipe_valid, writes rd=3 then rd=4 in order;
  - counter clears and stall_pipe=0.
- pipe_valid=1 rd=0 data=0xFFFF → RegWrite stays 0. MDU rd=0 accepted → consumed, fifo_count unchanged afterwards, RegWrite=0.
- Simultaneous push and pop: FIFO holds 1 entry, pipe idle, mdu_valid=1 → head written, new entry enqueued, fifo_count stays 1.
- Assert rst asynchronously with fifo_count=2 and RegWrite=1 → RegWrite=0 and fifo_count=0 without waiting for a clk edge; no stale entry is written after release.
